// File: rtl/register_bank_dump_pkg.sv
// rtl/register_bank_dump_pkg.sv - shared defaults and dump FSM state encoding for the GPR bank
package register_bank_dump_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/register_bank_dump_if.sv
// rtl/register_bank_dump_if.sv - write/read ports and handshaked dump port of the GPR bank
interface register_bank_dump_if
    import register_bank_dump_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = 2
) ();

    logic                         reg_write;
    logic [ADDR_W-1:0]            rw;
    logic [WIDTH-1:0]             busw;
    logic [NUM_READ*ADDR_W-1:0]   ra;
    logic [NUM_READ*WIDTH-1:0]    rd_data;
    logic                         dump_start;
    logic                         dump_valid;
    logic                         dump_ready;
    logic [WIDTH-1:0]             dump_data;
    logic [ADDR_W-1:0]            dump_index;
    logic                         dump_busy;
    logic                         dump_done;

    modport master (
        output reg_write, rw, busw, ra, dump_start, dump_ready,
        input  rd_data, dump_valid, dump_data, dump_index, dump_busy, dump_done
    );

    modport slave (
        input  reg_write, rw, busw, ra, dump_start, dump_ready,
        output rd_data, dump_valid, dump_data, dump_index, dump_busy, dump_done
    );

endinterface

// File: rtl/register_bank_dump_fsm.sv
// rtl/register_bank_dump_fsm.sv - sequential register dump engine, one word per LOAD/SEND pair
module register_bank_dump_fsm
    import register_bank_dump_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              ready,
    output logic [ADDR_W-1:0] rd_idx,
    input  logic [WIDTH-1:0]  rd_word,
    output logic              valid,
    output logic [WIDTH-1:0]  data,
    output logic [ADDR_W-1:0] index,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            index_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            index_q <= index_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        index_d = index_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                data_d  = rd_word;
                index_d = idx_q;
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (ready) begin
                    valid_d = 1'b0;
                    // terminal compare on LAST keeps the ADDR_W counter from wrapping
                    if (idx_q == LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_idx = idx_q;
    assign valid  = valid_q;
    assign data   = data_q;
    assign index  = index_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: rtl/register_bank_dump.sv
// rtl/register_bank_dump.sv - parametrised DLX GPR file with bypassed async reads and a sequential dump port
module register_bank_dump
    import register_bank_dump_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    register_bank_dump_if.slave  bus
);

    logic [WIDTH-1:0]  regs [DEPTH];
    logic [ADDR_W-1:0] dump_idx;
    logic [WIDTH-1:0]  dump_word;

    // reg0 is never written, so it keeps its reset value of zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (INIT_INDEX != 0) ? WIDTH'(i) : '0;
            end
        end else if (bus.reg_write && bus.rw != '0) begin
            regs[bus.rw] <= bus.busw;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = bus.ra[p*ADDR_W +: ADDR_W];
        assign bus.rd_data[p*WIDTH +: WIDTH] =
            (addr == '0)                                        ? '0       :
            (BYPASS != 0 && bus.reg_write && bus.rw == addr)    ? bus.busw :
                                                                  regs[addr];
    end

    // the dump samples through the same bypass path as the read ports
    assign dump_word =
        (dump_idx == '0)                                        ? '0       :
        (BYPASS != 0 && bus.reg_write && bus.rw == dump_idx)    ? bus.busw :
                                                                  regs[dump_idx];

    register_bank_dump_fsm #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fsm (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (bus.dump_start),
        .ready   (bus.dump_ready),
        .rd_idx  (dump_idx),
        .rd_word (dump_word),
        .valid   (bus.dump_valid),
        .data    (bus.dump_data),
        .index   (bus.dump_index),
        .busy    (bus.dump_busy),
        .done    (bus.dump_done)
    );

endmodule
